// File: rtl/cfu_pkg.sv
// Shared CFU-L2 definitions: standard function IDs, response status, context
// state/status word, and parameter-legality helpers.
package cfu_pkg;

  localparam int unsigned CFU_FUNC_ID_W_STD = 10;

  typedef enum logic [CFU_FUNC_ID_W_STD-1:0] {
    CFU_WRITE_STATE  = 10'd1020,
    CFU_READ_STATE   = 10'd1021,
    CFU_WRITE_STATUS = 10'd1022,
    CFU_READ_STATUS  = 10'd1023
  } cfid_t;

  typedef enum logic [1:0] {
    CFU_OK          = 2'd0,
    CFU_ERROR_FUNC  = 2'd1,
    CFU_ERROR_STATE = 2'd2,
    CFU_ERROR_OFF   = 2'd3
  } cfu_status_t;

  typedef enum logic [1:0] {
    CFU_CS_OFF   = 2'd0,
    CFU_CS_INIT  = 2'd1,
    CFU_CS_DIRTY = 2'd2,
    CFU_CS_CLEAN = 2'd3
  } cfu_cs_t;

  typedef struct packed {
    logic [19:0] rsvd;
    logic [9:0]  state_size;
    cfu_cs_t     cs;
  } cfu_csw_t;

  function automatic int unsigned cfu_id_w(int unsigned n_cfus);
    return (n_cfus > 1) ? $clog2(n_cfus) : 1;
  endfunction

  // One spare bit so out-of-range context indices are representable and reportable.
  function automatic int unsigned cfu_state_id_w(int unsigned n_states);
    return $clog2(n_states) + 1;
  endfunction

  function automatic bit cfu_data_w_ok(int unsigned w);
    return (w == 32) || (w == 64);
  endfunction

endpackage

// File: rtl/dotprod_pkg.sv
// Dot-product CFU function IDs, FSM encoding and function-ID decode helpers.
package dotprod_pkg;
  import cfu_pkg::*;

  typedef enum logic [CFU_FUNC_ID_W_STD-1:0] {
    DP_DOT_U     = 10'd0,
    DP_DOT_ACC_U = 10'd1,
    DP_DOT_S     = 10'd2,
    DP_DOT_ACC_S = 10'd3
  } dotprod_cfid_t;

  typedef enum logic [1:0] {
    FSM_IDLE = 2'd0,
    FSM_MAC  = 2'd1,
    FSM_RESP = 2'd2
  } fsm_t;

  function automatic logic is_signed(logic [CFU_FUNC_ID_W_STD-1:0] func);
    return (func == DP_DOT_S) || (func == DP_DOT_ACC_S);
  endfunction

  function automatic logic is_acc(logic [CFU_FUNC_ID_W_STD-1:0] func);
    return (func == DP_DOT_ACC_U) || (func == DP_DOT_ACC_S);
  endfunction

endpackage

// File: rtl/dotprod_lanes.sv
// Combinational LANES-wide element multiply and lane-sum reduction; products
// are sign- or zero-extended to SUM_W before summing.
module dotprod_lanes #(
  parameter int unsigned ELEM_W = 8,
  parameter int unsigned LANES  = 2,
  parameter int unsigned SUM_W  = 32
) (
  input  logic [LANES*ELEM_W-1:0] a_i,
  input  logic [LANES*ELEM_W-1:0] b_i,
  input  logic                    signed_i,
  output logic [SUM_W-1:0]        sum_o
);

  localparam int unsigned PROD_W = 2 * ELEM_W;

  logic [PROD_W-1:0] prod_c;
  logic [SUM_W-1:0]  ext_c;

  always_comb begin
    sum_o  = '0;
    prod_c = '0;
    ext_c  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (signed_i) begin
        prod_c = PROD_W'($signed(a_i[i*ELEM_W +: ELEM_W])) * PROD_W'($signed(b_i[i*ELEM_W +: ELEM_W]));
        ext_c  = SUM_W'($signed(prod_c));
      end else begin
        prod_c = PROD_W'(a_i[i*ELEM_W +: ELEM_W]) * PROD_W'(b_i[i*ELEM_W +: ELEM_W]);
        ext_c  = SUM_W'(prod_c);
      end
      sum_o = sum_o + ext_c;
    end
  end

endmodule

// File: rtl/dotprod_l2_cfu.sv
// Variable-latency CFU-L2 dot-product unit with per-context accumulators.
// Optional DOTPROD_L2_CFU_SAT_EN: saturating accumulate for funcs 1/3.
module dotprod_l2_cfu
  import cfu_pkg::*;
  import dotprod_pkg::*;
#(
  parameter int unsigned CFU_N_CFUS    = 1,
  parameter int unsigned CFU_N_STATES  = 2,
  parameter int unsigned CFU_FUNC_ID_W = 10,
  parameter int unsigned CFU_DATA_W    = 32,
  parameter int unsigned ELEM_W        = 8,
  parameter int unsigned LANES         = 2,
  localparam int unsigned CFU_CFU_ID_W   = cfu_id_w(CFU_N_CFUS),
  localparam int unsigned CFU_STATE_ID_W = cfu_state_id_w(CFU_N_STATES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_en,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [CFU_CFU_ID_W-1:0]   req_cfu,
  input  logic [CFU_STATE_ID_W-1:0] req_state,
  input  logic [CFU_FUNC_ID_W-1:0]  req_func,
  input  logic [CFU_DATA_W-1:0]     req_data0,
  input  logic [CFU_DATA_W-1:0]     req_data1,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output cfu_status_t               resp_status,
  output logic [CFU_DATA_W-1:0]     resp_data
);

  localparam int unsigned E       = CFU_DATA_W / ELEM_W;
  localparam int unsigned P       = E / LANES;
  localparam int unsigned CNT_W   = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned IDX_W   = (CFU_N_STATES > 1) ? $clog2(CFU_N_STATES) : 1;
  localparam int unsigned SLICE_W = LANES * ELEM_W;
`ifdef DOTPROD_L2_CFU_SAT_EN
  localparam int unsigned PS_W    = CFU_DATA_W + $clog2(E);
  localparam int unsigned SW      = PS_W + 1;
`else
  localparam int unsigned PS_W    = CFU_DATA_W;
`endif

  if (!cfu_data_w_ok(CFU_DATA_W) || CFU_FUNC_ID_W != $bits(cfid_t) || CFU_N_STATES < 1 ||
      ELEM_W > CFU_DATA_W || (E % LANES) != 0) begin : g_param_err
    $error("dotprod_l2_cfu: illegal parameter set");
  end

  fsm_t                  fsm_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [PS_W-1:0]       psum_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  sgn_q, accf_q;
  logic [CFU_DATA_W-1:0] a_q, b_q;
  logic [CFU_DATA_W-1:0] acc_q [CFU_N_STATES];
  cfu_cs_t               cs_q  [CFU_N_STATES];
  logic                  req_ready_q, resp_valid_q;
  cfu_status_t           resp_status_q;
  logic [CFU_DATA_W-1:0] resp_data_q;

  logic                  state_bad_c, func_dot_c, func_std_c, func_sts_c;
  logic [IDX_W-1:0]      ridx_c;
  cfu_cs_t               cur_cs_c, new_cs_c;
  cfu_csw_t              csw_c;
  cfu_status_t           err_c;
  logic [SLICE_W-1:0]    a_sl_c, b_sl_c;
  logic [PS_W-1:0]       lane_sum_c, psum_nxt_c;
  logic [CFU_DATA_W-1:0] base_c, result_c;
  logic                  unused_c;

  assign unused_c = ^req_cfu;

  // Request decode and error precedence: bad state, then context off, then unknown func.
  always_comb begin
    state_bad_c = (req_state >= CFU_STATE_ID_W'(CFU_N_STATES));
    ridx_c      = state_bad_c ? '0 : IDX_W'(req_state);
    cur_cs_c    = cs_q[ridx_c];
    new_cs_c    = cfu_cs_t'(req_data0[1:0]);
    func_dot_c  = (req_func < CFU_FUNC_ID_W'(4));
    func_std_c  = (req_func >= CFU_WRITE_STATE);
    func_sts_c  = (req_func == CFU_WRITE_STATUS) || (req_func == CFU_READ_STATUS);
    csw_c       = '{rsvd: '0, state_size: 10'd1, cs: cur_cs_c};
    if (state_bad_c)                              err_c = CFU_ERROR_STATE;
    else if (cur_cs_c == CFU_CS_OFF && !func_sts_c) err_c = CFU_ERROR_OFF;
    else if (!func_dot_c && !func_std_c)          err_c = CFU_ERROR_FUNC;
    else                                          err_c = CFU_OK;
  end

  assign a_sl_c = SLICE_W'(a_q >> (32'(cnt_q) * SLICE_W));
  assign b_sl_c = SLICE_W'(b_q >> (32'(cnt_q) * SLICE_W));

  dotprod_lanes #(
    .ELEM_W (ELEM_W),
    .LANES  (LANES),
    .SUM_W  (PS_W)
  ) u_lanes (
    .a_i      (a_sl_c),
    .b_i      (b_sl_c),
    .signed_i (sgn_q),
    .sum_o    (lane_sum_c)
  );

  // Final-pass result: base plus completed partial sum, optionally clamped.
`ifdef DOTPROD_L2_CFU_SAT_EN
  logic signed [SW-1:0] sw_c, smax_c, smin_c;
  logic [SW-1:0]        uw_c;
`endif
  always_comb begin
    psum_nxt_c = psum_q + lane_sum_c;
    base_c     = accf_q ? acc_q[idx_q] : '0;
`ifdef DOTPROD_L2_CFU_SAT_EN
    smax_c   = SW'($signed({1'b0, {(CFU_DATA_W-1){1'b1}}}));
    smin_c   = SW'($signed({1'b1, {(CFU_DATA_W-1){1'b0}}}));
    sw_c     = SW'($signed(base_c)) + SW'($signed(psum_nxt_c));
    uw_c     = SW'(base_c) + SW'(psum_nxt_c);
    result_c = CFU_DATA_W'(psum_nxt_c);
    if (accf_q && sgn_q) begin
      if (sw_c > smax_c)      result_c = {1'b0, {(CFU_DATA_W-1){1'b1}}};
      else if (sw_c < smin_c) result_c = {1'b1, {(CFU_DATA_W-1){1'b0}}};
      else                    result_c = CFU_DATA_W'(sw_c);
    end else if (accf_q) begin
      if (uw_c > SW'({CFU_DATA_W{1'b1}})) result_c = '1;
      else                                result_c = CFU_DATA_W'(uw_c);
    end
`else
    result_c = base_c + CFU_DATA_W'(psum_nxt_c);
`endif
  end

  // Control FSM, context storage and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q         <= FSM_IDLE;
      cnt_q         <= '0;
      psum_q        <= '0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_status_q <= CFU_OK;
      resp_data_q   <= '0;
      for (int unsigned i = 0; i < CFU_N_STATES; i++) begin
        acc_q[i] <= '0;
        cs_q[i]  <= CFU_CS_INIT;
      end
    end else if (clk_en) begin
      case (fsm_q)
        FSM_IDLE: begin
          if (req_valid) begin
            req_ready_q   <= 1'b0;
            fsm_q         <= FSM_RESP;
            resp_valid_q  <= 1'b1;
            resp_status_q <= err_c;
            resp_data_q   <= '0;
            if (err_c == CFU_OK) begin
              if (func_dot_c) begin
                fsm_q        <= FSM_MAC;
                resp_valid_q <= 1'b0;
                idx_q        <= ridx_c;
                sgn_q        <= is_signed(CFU_FUNC_ID_W_STD'(req_func));
                accf_q       <= is_acc(CFU_FUNC_ID_W_STD'(req_func));
                a_q          <= req_data0;
                b_q          <= req_data1;
                cnt_q        <= '0;
                psum_q       <= '0;
              end else begin
                case (req_func)
                  CFU_WRITE_STATE: begin
                    acc_q[ridx_c] <= req_data0;
                    cs_q[ridx_c]  <= CFU_CS_DIRTY;
                    resp_data_q   <= req_data0;
                  end
                  CFU_READ_STATE: resp_data_q <= acc_q[ridx_c];
                  CFU_WRITE_STATUS: begin
                    resp_data_q  <= CFU_DATA_W'(csw_c);
                    cs_q[ridx_c] <= new_cs_c;
                    if (new_cs_c == CFU_CS_OFF || new_cs_c == CFU_CS_INIT) acc_q[ridx_c] <= '0;
                  end
                  CFU_READ_STATUS: resp_data_q <= CFU_DATA_W'(csw_c);
                  default: ;
                endcase
              end
            end
          end
        end
        FSM_MAC: begin
          psum_q <= psum_nxt_c;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(P - 1)) begin
            acc_q[idx_q]  <= result_c;
            cs_q[idx_q]   <= CFU_CS_DIRTY;
            resp_data_q   <= result_c;
            resp_status_q <= CFU_OK;
            resp_valid_q  <= 1'b1;
            fsm_q         <= FSM_RESP;
          end
        end
        FSM_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            fsm_q        <= FSM_IDLE;
          end
        end
        default: fsm_q <= FSM_IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_status = resp_status_q;
  assign resp_data   = resp_data_q;

endmodule
